// File: rtl/bus_pkg.sv
// Shared definitions for the bus transfer controller: widths, source/destination
// codes and the transfer FSM state type.
package bus_pkg;

  localparam int unsigned SEL_W   = 5;
  localparam int unsigned NUM_SRC = 26;
  localparam int unsigned NUM_DST = 24;

  localparam logic [SEL_W-1:0] DST_LIMIT = SEL_W'(NUM_DST);

  localparam logic [SEL_W-1:0]
    SRC_R0  = 5'd0,  SRC_R1  = 5'd1,  SRC_R2  = 5'd2,  SRC_R3  = 5'd3,
    SRC_R4  = 5'd4,  SRC_R5  = 5'd5,  SRC_R6  = 5'd6,  SRC_R7  = 5'd7,
    SRC_R8  = 5'd8,  SRC_R9  = 5'd9,  SRC_R10 = 5'd10, SRC_R11 = 5'd11,
    SRC_R12 = 5'd12, SRC_R13 = 5'd13, SRC_R14 = 5'd14, SRC_R15 = 5'd15,
    SRC_HI  = 5'd16, SRC_LO  = 5'd17, SRC_ZHI = 5'd18, SRC_ZLO = 5'd19,
    SRC_PC  = 5'd20, SRC_MDR = 5'd21, SRC_INPORT = 5'd22, SRC_C_SIGN_EXT = 5'd23,
    SRC_IR  = 5'd24, SRC_Y   = 5'd25;

  localparam logic [SEL_W-1:0]
    DST_R0  = 5'd0,  DST_R1  = 5'd1,  DST_R2  = 5'd2,  DST_R3  = 5'd3,
    DST_R4  = 5'd4,  DST_R5  = 5'd5,  DST_R6  = 5'd6,  DST_R7  = 5'd7,
    DST_R8  = 5'd8,  DST_R9  = 5'd9,  DST_R10 = 5'd10, DST_R11 = 5'd11,
    DST_R12 = 5'd12, DST_R13 = 5'd13, DST_R14 = 5'd14, DST_R15 = 5'd15,
    DST_HI  = 5'd16, DST_LO  = 5'd17, DST_PC  = 5'd18, DST_MDR = 5'd19,
    DST_MAR = 5'd20, DST_IR  = 5'd21, DST_Y   = 5'd22, DST_Z   = 5'd23;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    LOAD
  } state_t;

endpackage

// File: rtl/bus_src_encoder.sv
// Priority encoder for one-hot bus source strobes: lowest set bit wins, with
// flags for multi-hot and zero-hot requests.
module bus_src_encoder
  import bus_pkg::*;
(
  input  logic [NUM_SRC-1:0] src,
  output logic [SEL_W-1:0]   code,
  output logic               multi,
  output logic               none
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    code = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (src[i-1]) code = SEL_W'(i - 1);
    end
  end

  assign none  = (src == '0);
  assign multi = |(src & (src - 1'b1));

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Bus transfer controller: drives the bus mux select, waits one settle cycle,
// then pulses the destination load enable. Optional skid buffer: BUS_XFER_SKID_EN.
module bus_transfer_ctrl
  import bus_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [NUM_SRC-1:0] req_src,
  input  logic [SEL_W-1:0]   req_dst,
  output logic [SEL_W-1:0]   BusMuxSelect,
  output logic [NUM_DST-1:0] load_en,
  output logic               done,
  input  logic               err_clr,
  output logic               err_multi,
  output logic               err_none,
  output logic               err_dst
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] dst_q, dst_d;

  logic [SEL_W-1:0] enc_code;
  logic             enc_multi, enc_none;
  logic             accept, start_new, dst_bad;

  bus_src_encoder u_enc (
    .src   (req_src),
    .code  (enc_code),
    .multi (enc_multi),
    .none  (enc_none)
  );

  assign accept    = req_valid && req_ready;
  assign start_new = accept && !enc_none;
  assign dst_bad   = (req_dst >= DST_LIMIT);

`ifdef BUS_XFER_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic [SEL_W-1:0] skid_dst_q, skid_dst_d;

  assign req_ready = (state_q == IDLE) || !skid_valid_q;
`else
  assign req_ready = (state_q == IDLE);
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dst_d   = dst_q;
`ifdef BUS_XFER_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_sel_d   = skid_sel_q;
    skid_dst_d   = skid_dst_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_new) begin
          sel_d   = enc_code;
          dst_d   = req_dst;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = LOAD;
`ifdef BUS_XFER_SKID_EN
        if (start_new) begin
          skid_valid_d = 1'b1;
          skid_sel_d   = enc_code;
          skid_dst_d   = req_dst;
        end
`endif
      end
      LOAD: begin
        state_d = IDLE;
`ifdef BUS_XFER_SKID_EN
        // A request taken during LOAD bypasses the skid and starts straight away.
        if (skid_valid_q) begin
          sel_d        = skid_sel_q;
          dst_d        = skid_dst_q;
          skid_valid_d = 1'b0;
          state_d      = DRIVE;
        end else if (start_new) begin
          sel_d   = enc_code;
          dst_d   = req_dst;
          state_d = DRIVE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_en = '0;
    done    = 1'b0;
    if (state_q == LOAD) begin
      done = 1'b1;
      if (dst_q < DST_LIMIT) load_en = NUM_DST'(1) << dst_q;
    end
  end

  assign BusMuxSelect = sel_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      dst_q     <= '0;
      err_multi <= 1'b0;
      err_none  <= 1'b0;
      err_dst   <= 1'b0;
`ifdef BUS_XFER_SKID_EN
      skid_valid_q <= 1'b0;
      skid_sel_q   <= '0;
      skid_dst_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      dst_q     <= dst_d;
      err_multi <= (err_multi && !err_clr) || (accept && enc_multi);
      err_none  <= (err_none  && !err_clr) || (accept && enc_none);
      err_dst   <= (err_dst   && !err_clr) || (accept && dst_bad);
`ifdef BUS_XFER_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_sel_q   <= skid_sel_d;
      skid_dst_q   <= skid_dst_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Self-checking bench for bus_transfer_ctrl: directed vector table, corner-case
// sequences and a randomized run against a transfer-timeline reference model.
`timescale 1ns/1ps
module tb_bus_transfer_ctrl;
  import bus_pkg::*;

`ifdef BUS_XFER_SKID_EN
  localparam bit SKID = 1'b1;
  localparam int CAP  = 2;
  localparam int GAP  = 2;
`else
  localparam bit SKID = 1'b0;
  localparam int CAP  = 1;
  localparam int GAP  = 3;
`endif

  logic               clock = 1'b0;
  logic               clear;
  logic               req_valid;
  logic               req_ready;
  logic [NUM_SRC-1:0] req_src;
  logic [SEL_W-1:0]   req_dst;
  logic [SEL_W-1:0]   BusMuxSelect;
  logic [NUM_DST-1:0] load_en;
  logic               done;
  logic               err_clr;
  logic               err_multi, err_none, err_dst;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  bus_transfer_ctrl dut (
    .clock        (clock),
    .clear        (clear),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_src      (req_src),
    .req_dst      (req_dst),
    .BusMuxSelect (BusMuxSelect),
    .load_en      (load_en),
    .done         (done),
    .err_clr      (err_clr),
    .err_multi    (err_multi),
    .err_none     (err_none),
    .err_dst      (err_dst)
  );

  typedef struct {
    logic [NUM_SRC-1:0] src;
    logic [SEL_W-1:0]   dst;
    bit                 clr_before;
    logic [SEL_W-1:0]   sel;
    logic [NUM_DST-1:0] load;
    bit                 xfer;
    bit                 e_multi;
    bit                 e_none;
    bit                 e_dst;
  } vec_t;

  typedef struct {
    int code;
    int dst;
    int start;
  } xfer_t;

  vec_t  vecs[6];
  xfer_t q[$];

  function automatic logic [NUM_SRC-1:0] oh(input int i);
    logic [NUM_SRC-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [NUM_DST-1:0] dl(input int i);
    logic [NUM_DST-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    req_src   = '0;
    req_dst   = '0;
    err_clr   = 1'b0;
    clear     = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 clear = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clock); #1;
    err_clr = 1'b0;
    check("clr_multi", err_multi, 0);
    check("clr_none",  err_none,  0);
    check("clr_dst",   err_dst,   0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if (v.clr_before) pulse_clr();
    check($sformatf("v%0d_ready_idle", idx), req_ready, 1);
    req_valid = 1'b1;
    req_src   = v.src;
    req_dst   = v.dst;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_src   = '0;
    check($sformatf("v%0d_sel", idx), BusMuxSelect, v.sel);
    check($sformatf("v%0d_ready1", idx), req_ready, SKID || !v.xfer);
    check($sformatf("v%0d_load1", idx), load_en, 0);
    check($sformatf("v%0d_done1", idx), done, 0);
    @(posedge clock); #1;
    check($sformatf("v%0d_load2", idx), load_en, v.load);
    check($sformatf("v%0d_done2", idx), done, v.xfer);
    check($sformatf("v%0d_sel2", idx), BusMuxSelect, v.sel);
    check($sformatf("v%0d_ready2", idx), req_ready, SKID || !v.xfer);
    @(posedge clock); #1;
    check($sformatf("v%0d_ready3", idx), req_ready, 1);
    check($sformatf("v%0d_done3", idx), done, 0);
    check($sformatf("v%0d_sel3", idx), BusMuxSelect, v.sel);
    check($sformatf("v%0d_err_multi", idx), err_multi, v.e_multi);
    check($sformatf("v%0d_err_none", idx), err_none, v.e_none);
    check($sformatf("v%0d_err_dst", idx), err_dst, v.e_dst);
  endtask

  initial begin
    int codes[4];
    int dsts[4];
    int sent, got, last, cyc;
    bit will_accept;

    vecs[0] = '{oh(20), 5'd21, 1'b0, 5'd20, dl(21), 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{'0,     5'd2,  1'b0, 5'd20, '0,     1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{oh(3) | oh(17), 5'd5, 1'b0, 5'd3, dl(5), 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{oh(25), 5'd30, 1'b1, 5'd25, '0,     1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{oh(23), 5'd23, 1'b1, 5'd23, dl(23), 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{{NUM_SRC{1'b1}}, 5'd24, 1'b1, 5'd0, '0, 1'b1, 1'b1, 1'b0, 1'b1};

    do_reset();
    check("rst_ready", req_ready, 1);
    check("rst_sel",   BusMuxSelect, 0);
    check("rst_load",  load_en, 0);
    check("rst_done",  done, 0);
    check("rst_errs",  {err_multi, err_none, err_dst}, 0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // New error in the same cycle as err_clr: the new error survives.
    req_valid = 1'b1;
    req_src   = oh(7) | oh(9);
    req_dst   = 5'd4;
    err_clr   = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_src   = '0;
    err_clr   = 1'b0;
    check("clrwin_multi", err_multi, 1);
    check("clrwin_none",  err_none, 0);
    check("clrwin_dst",   err_dst, 0);
    check("clrwin_sel",   BusMuxSelect, 7);
    repeat (2) @(posedge clock);
    #1;

    // Clear during DRIVE of R5 -> Y aborts the transfer.
    req_valid = 1'b1;
    req_src   = oh(5);
    req_dst   = 5'd22;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_src   = '0;
    check("abort_sel_drive", BusMuxSelect, 5);
    clear = 1'b1;
    #1;
    check("abort_sel", BusMuxSelect, 0);
    check("abort_ready", req_ready, 1);
    check("abort_errs", {err_multi, err_none, err_dst}, 0);
    #1 clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check($sformatf("abort_load%0d", k), load_en, 0);
      check($sformatf("abort_done%0d", k), done, 0);
    end

    // Held request valid: four transfers back to back.
    codes = '{2, 16, 21, 24};
    dsts  = '{0, 17, 19, 22};
    sent = 0; got = 0; last = -1; cyc = 0;
    req_valid = 1'b1;
    req_src   = oh(codes[0]);
    req_dst   = 5'(dsts[0]);
    while (got < 4 && cyc < 60) begin
      will_accept = req_ready && req_valid;
      @(posedge clock); #1;
      cyc++;
      if (will_accept) begin
        sent++;
        if (sent < 4) begin
          req_src = oh(codes[sent]);
          req_dst = 5'(dsts[sent]);
        end else begin
          req_valid = 1'b0;
          req_src   = '0;
        end
      end
      if (done) begin
        check($sformatf("b2b_load%0d", got), load_en, dl(dsts[got]));
        check($sformatf("b2b_sel%0d", got), BusMuxSelect, codes[got]);
        if (got > 0) check($sformatf("b2b_gap%0d", got), cyc - last, GAP);
        last = cyc;
        got++;
      end
    end
    check("b2b_count", got, 4);
    req_valid = 1'b0;

    // Randomized run against a timeline model: each transfer starts DRIVE at
    // max(accept edge, previous start + 2) and loads one edge later.
    do_reset();
    begin
      int e, last_start, code, start;
      bit m_ready, acc, exp_done;
      bit m_multi, m_none, m_dst;
      logic [SEL_W-1:0]   m_sel;
      logic [NUM_DST-1:0] exp_load;
      int kind;
      q.delete();
      e = 0; last_start = -100;
      m_multi = 0; m_none = 0; m_dst = 0; m_sel = '0;
      m_ready = 1'b1;
      for (int n = 0; n < 400; n++) begin
        check("rnd_ready", req_ready, m_ready);
        req_valid = ($urandom_range(3) != 0);
        kind = $urandom_range(9);
        if (kind == 0)      req_src = '0;
        else if (kind <= 2) req_src = NUM_SRC'($urandom);
        else                req_src = oh($urandom_range(NUM_SRC - 1));
        req_dst = ($urandom_range(7) == 0) ? 5'($urandom_range(31, 24)) : 5'($urandom_range(23, 0));
        err_clr = ($urandom_range(7) == 0);
        acc = req_valid && m_ready;
        @(posedge clock);
        e++;
        m_multi = (m_multi && !err_clr) || (acc && $countones(req_src) > 1);
        m_none  = (m_none  && !err_clr) || (acc && req_src == '0);
        m_dst   = (m_dst   && !err_clr) || (acc && req_dst >= 5'd24);
        if (acc && req_src != '0) begin
          code = 0;
          for (int i = 0; i < NUM_SRC; i++) begin
            if (req_src[i]) begin code = i; break; end
          end
          start = (e > last_start + 2) ? e : last_start + 2;
          q.push_back('{code, int'(req_dst), start});
          last_start = start;
        end
        #1;
        while (q.size() > 0 && q[0].start + 2 <= e) void'(q.pop_front());
        exp_load = '0;
        exp_done = 1'b0;
        foreach (q[i]) begin
          if (q[i].start == e) m_sel = 5'(q[i].code);
          if (q[i].start + 1 == e) begin
            exp_done = 1'b1;
            if (q[i].dst < NUM_DST) exp_load = dl(q[i].dst);
          end
        end
        check("rnd_sel",   BusMuxSelect, m_sel);
        check("rnd_load",  load_en, exp_load);
        check("rnd_done",  done, exp_done);
        check("rnd_multi", err_multi, m_multi);
        check("rnd_none",  err_none, m_none);
        check("rnd_dst",   err_dst, m_dst);
        m_ready = (q.size() < CAP);
      end
    end
    req_valid = 1'b0;
    err_clr   = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
